// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package mux_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  // Index width for n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);

  int unsigned      sum;
  logic [SEL_W-1:0] idx;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum = 32'(ptr) + k;
      idx = SEL_W'(sum % N_CH);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel valid/ready multiplexer with a registered output stage, selecting
// either by the sel port or by round-robin arbitration.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MODE   = MODE_FIXED,
  parameter int unsigned SEL_W  = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch
);

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_ch_q;

  logic              load_en;
  logic              grant_valid;
  logic [SEL_W-1:0]  winner;
  logic              xfer;
  logic [DATA_W-1:0] ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_data[i]  = in_data[i*DATA_W +: DATA_W];
    assign in_ready[i] = rst_n && load_en && grant_valid && (winner == SEL_W'(i));
  end

  // The register can take a word when empty or when it is being drained this cycle.
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = rst_n && load_en && grant_valid;

  if (MODE == MODE_RR) begin : g_rr
    logic [SEL_W-1:0] ptr_q, ptr_d;

    rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
    ) u_arb (
      .req         (in_valid),
      .ptr         (ptr_q),
      .grant_idx   (winner),
      .grant_valid (grant_valid)
    );

    always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
        ptr_d = (winner == SEL_W'(N_CH - 1)) ? '0 : winner + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_fixed
    assign winner = sel;

    // Out-of-range selects never grant.
    always_comb begin
      grant_valid = 1'b0;
      if (32'(sel) < N_CH) begin
        grant_valid = in_valid[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ch_data[winner];
      out_ch_q    <= winner;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
